// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ball_engine
//  Brief    : Pong ball motion, paddle bounce/steering, scoring and game FSM.
//  Revision : 1.0  initial release
// ============================================================================
module ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_MAX       = 360,
  parameter int BALL_R      = 4,
  parameter int BAR_HALF    = 30,
  parameter int BAR_W       = 5,
  parameter int BAR_1_X     = 20,
  parameter int BAR_2_X     = 600,
  parameter int CENTER_X    = 310,
  parameter int CENTER_Y    = 180,
  parameter int VH          = 1,
  parameter int VV_MAX      = 3,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [9:0]         bar_1_y,
  input  logic [9:0]         bar_2_y,
  output logic [10:0]        x,
  output logic [9:0]         y,
  output logic               point_1,
  output logic               point_2,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam int c_VY_W  = (VV_MAX > 0) ? $clog2(VV_MAX + 1) : 1;
  localparam int c_CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic signed [11:0] c_VH      = 12'(VH);
  localparam logic signed [11:0] c_BR      = 12'(BALL_R);
  localparam logic signed [11:0] c_BAR1_L  = 12'(BAR_1_X);
  localparam logic signed [11:0] c_BAR1_R  = 12'(BAR_1_X + BAR_W);
  localparam logic signed [11:0] c_BAR2_L  = 12'(BAR_2_X);
  localparam logic signed [11:0] c_BAR2_R  = 12'(BAR_2_X + BAR_W);
  localparam logic signed [11:0] c_REACH   = 12'(BAR_HALF + BALL_R);
  localparam logic signed [11:0] c_THIRD   = 12'(BAR_HALF / 3);
  localparam logic signed [11:0] c_Y_HI    = 12'(V_MAX - 1 - BALL_R);
  localparam logic signed [11:0] c_X_END   = 12'(H_RES - 1);
  localparam logic [9:0]         c_Y_TOP   = 10'(V_MAX - 1 - BALL_R);
  localparam logic [9:0]         c_Y_BOT   = 10'(BALL_R);
  localparam logic [10:0]        c_CX      = 11'(CENTER_X);
  localparam logic [9:0]         c_CY      = 10'(CENTER_Y);
  localparam logic [c_VY_W-1:0]  c_VV_MAX  = c_VY_W'(VV_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] c_WIN     = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_vx_dir;
  logic                r_vy_dir;
  logic [c_VY_W-1:0]   r_vy_mag;
  logic [c_CNT_W-1:0]  r_cnt;

  logic signed [11:0]  w_x_cur, w_y_cur, w_bar_1, w_bar_2, w_vy;
  logic signed [11:0]  w_x_new, w_y_new, w_d_1, w_d_2, w_d;
  logic                w_hit_1, w_hit_2, w_hit, w_steer;
  logic                w_vy_dir_n;
  logic [c_VY_W-1:0]   w_vy_mag_n;
  logic [9:0]          w_y_lim;
  logic                w_score_1, w_score_2;
  logic [SCORE_W-1:0]  w_s1_inc, w_s2_inc;

  // All position math is 12-bit signed so x-VH / y-vy never wrap below zero.
  always_comb begin
    w_x_cur = $signed({1'b0, x});
    w_y_cur = $signed({2'b00, y});
    w_bar_1 = $signed({2'b00, bar_1_y});
    w_bar_2 = $signed({2'b00, bar_2_y});
    w_vy    = $signed(12'(r_vy_mag));
    w_x_new = r_vx_dir ? (w_x_cur + c_VH) : (w_x_cur - c_VH);
    w_y_new = r_vy_dir ? (w_y_cur + w_vy) : (w_y_cur - w_vy);
    w_d_1   = w_y_new - w_bar_1;
    w_d_2   = w_y_new - w_bar_2;

    w_hit_1 = !r_vx_dir && (w_x_new - c_BR <= c_BAR1_R) && (w_x_new + c_BR >= c_BAR1_L)
              && (w_d_1 <= c_REACH) && (w_d_1 >= -c_REACH);
    w_hit_2 = r_vx_dir && (w_x_new + c_BR >= c_BAR2_L) && (w_x_new - c_BR <= c_BAR2_R)
              && (w_d_2 <= c_REACH) && (w_d_2 >= -c_REACH);
    w_hit   = w_hit_1 || w_hit_2;
    w_d     = w_hit_1 ? w_d_1 : w_d_2;
    w_steer = (w_d > c_THIRD);

    w_vy_dir_n = r_vy_dir;
    w_vy_mag_n = r_vy_mag;
    if (w_hit && ((w_d > c_THIRD) || (w_d < -c_THIRD))) begin
      if (r_vy_mag == '0) begin
        w_vy_dir_n = w_steer;
        w_vy_mag_n = c_VY_W'(1);
      end else if (r_vy_dir == w_steer) begin
        if (r_vy_mag != c_VV_MAX) w_vy_mag_n = r_vy_mag + 1'b1;
      end else begin
        w_vy_mag_n = r_vy_mag - 1'b1;
      end
    end

    // Wall reflection overrides any steering on the vertical direction.
    w_y_lim = w_y_new[9:0];
    if (w_y_new > c_Y_HI) begin
      w_y_lim    = c_Y_TOP;
      w_vy_dir_n = 1'b0;
    end else if (w_y_new < c_BR) begin
      w_y_lim    = c_Y_BOT;
      w_vy_dir_n = 1'b1;
    end

    w_score_1 = !w_hit && (w_x_new + c_BR >= c_X_END);
    w_score_2 = !w_hit && !w_score_1 && (w_x_new <= c_BR);
    w_s1_inc  = score_1 + 1'b1;
    w_s2_inc  = score_2 + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_SERVE;
      x        <= c_CX;
      y        <= c_CY;
      r_vx_dir <= 1'b1;
      r_vy_dir <= 1'b0;
      r_vy_mag <= '0;
      r_cnt    <= '0;
      score_1  <= '0;
      score_2  <= '0;
      point_1  <= 1'b0;
      point_2  <= 1'b0;
    end else begin
      point_1 <= 1'b0;
      point_2 <= 1'b0;
      case (r_state)
        S_SERVE: begin
          x        <= c_CX;
          y        <= c_CY;
          r_vy_mag <= '0;
          if (tick) begin
            if (r_cnt == c_CNT_END) begin
              r_cnt   <= '0;
              r_state <= S_PLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (w_score_1 || w_score_2) begin
              x        <= c_CX;
              y        <= c_CY;
              r_vy_mag <= '0;
              r_cnt    <= '0;
              if (w_score_1) begin
                point_1  <= 1'b1;
                score_1  <= w_s1_inc;
                r_vx_dir <= 1'b0;
                r_state  <= (w_s1_inc == c_WIN) ? S_OVER : S_SERVE;
              end else begin
                point_2  <= 1'b1;
                score_2  <= w_s2_inc;
                r_vx_dir <= 1'b1;
                r_state  <= (w_s2_inc == c_WIN) ? S_OVER : S_SERVE;
              end
            end else begin
              x        <= w_x_new[10:0];
              y        <= w_y_lim;
              r_vy_dir <= w_vy_dir_n;
              r_vy_mag <= w_vy_mag_n;
              if (w_hit_1)      r_vx_dir <= 1'b1;
              else if (w_hit_2) r_vx_dir <= 1'b0;
            end
          end
        end
        S_OVER: begin
          x <= c_CX;
          y <= c_CY;
          if (start) begin
            score_1  <= '0;
            score_2  <= '0;
            r_vx_dir <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_SERVE;
          end
        end
        default: r_state <= S_SERVE;
      endcase
    end
  end

  assign state     = r_state;
  assign game_over = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ball_engine
//  Brief    : Randomized self-checking bench for ball_engine against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ball_engine;

  localparam int H_RES = 640, V_MAX = 360, BALL_R = 4, BAR_HALF = 30, BAR_W = 5;
  localparam int BAR_1_X = 20, BAR_2_X = 600, CENTER_X = 310, CENTER_Y = 180;
  localparam int VH = 1, VV_MAX = 3, SERVE_TICKS = 60, WIN_SCORE = 7, SCORE_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               tick;
  logic               start;
  logic [9:0]         bar_1_y;
  logic [9:0]         bar_2_y;
  logic [10:0]        x;
  logic [9:0]         y;
  logic               point_1;
  logic               point_2;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic [1:0]         state;
  logic               game_over;

  ball_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .bar_1_y(bar_1_y), .bar_2_y(bar_2_y), .x(x), .y(y),
    .point_1(point_1), .point_2(point_2), .score_1(score_1), .score_2(score_2),
    .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game state as plain integers
  int m_x, m_y, m_vx, m_vyd, m_vym, m_cnt, m_state, m_s1, m_s2, m_p1, m_p2;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = CENTER_X; m_y = CENTER_Y; m_vx = 1; m_vyd = 0; m_vym = 0;
    m_cnt = 0; m_state = 0; m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input int b1, input int b2);
    int xn, yn, d, dir;
    bit h1, h2;
    m_p1 = 0; m_p2 = 0;
    if (m_state == 0) begin
      m_x = CENTER_X; m_y = CENTER_Y; m_vym = 0;
      if (t) begin
        if (m_cnt == SERVE_TICKS - 1) begin m_cnt = 0; m_state = 1; end
        else m_cnt++;
      end
    end else if (m_state == 1) begin
      if (t) begin
        xn = m_vx ? m_x + VH : m_x - VH;
        yn = m_vyd ? m_y + m_vym : m_y - m_vym;
        h1 = (m_vx == 0) && (xn - BALL_R <= BAR_1_X + BAR_W) && (xn + BALL_R >= BAR_1_X)
             && ((yn - b1 <= BAR_HALF + BALL_R) && (b1 - yn <= BAR_HALF + BALL_R));
        h2 = (m_vx == 1) && (xn + BALL_R >= BAR_2_X) && (xn - BALL_R <= BAR_2_X + BAR_W)
             && ((yn - b2 <= BAR_HALF + BALL_R) && (b2 - yn <= BAR_HALF + BALL_R));
        if (h1 || h2) begin
          d = yn - (h1 ? b1 : b2);
          dir = -1;
          if (d > BAR_HALF / 3) dir = 1;
          else if (d < -(BAR_HALF / 3)) dir = 0;
          if (dir >= 0) begin
            if (m_vym == 0) begin m_vyd = dir; m_vym = 1; end
            else if (m_vyd == dir) m_vym = (m_vym < VV_MAX) ? m_vym + 1 : VV_MAX;
            else m_vym--;
          end
          m_vx = h1 ? 1 : 0;
        end
        if (!(h1 || h2) && (xn + BALL_R >= H_RES - 1)) begin
          m_p1 = 1; m_s1++; m_vx = 0;
          m_x = CENTER_X; m_y = CENTER_Y; m_vym = 0; m_cnt = 0;
          m_state = (m_s1 == WIN_SCORE) ? 2 : 0;
        end else if (!(h1 || h2) && (xn <= BALL_R)) begin
          m_p2 = 1; m_s2++; m_vx = 1;
          m_x = CENTER_X; m_y = CENTER_Y; m_vym = 0; m_cnt = 0;
          m_state = (m_s2 == WIN_SCORE) ? 2 : 0;
        end else begin
          m_x = xn;
          if (yn > V_MAX - 1 - BALL_R) begin m_y = V_MAX - 1 - BALL_R; m_vyd = 0; end
          else if (yn < BALL_R) begin m_y = BALL_R; m_vyd = 1; end
          else m_y = yn;
        end
      end
    end else begin
      m_x = CENTER_X; m_y = CENTER_Y;
      if (s) begin m_s1 = 0; m_s2 = 0; m_vx = 1; m_cnt = 0; m_state = 0; end
    end
  endtask

  task automatic compare_all(input string ph);
    check_value({ph, ".x"}, 32'(x), m_x);
    check_value({ph, ".y"}, 32'(y), m_y);
    check_value({ph, ".state"}, 32'(state), m_state);
    check_value({ph, ".game_over"}, 32'(game_over), (m_state == 2) ? 1 : 0);
    check_value({ph, ".point_1"}, 32'(point_1), m_p1);
    check_value({ph, ".point_2"}, 32'(point_2), m_p2);
    check_value({ph, ".score_1"}, 32'(score_1), m_s1);
    check_value({ph, ".score_2"}, 32'(score_2), m_s2);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive_step(input string ph, input bit t, input bit s, input int b1, input int b2);
    tick = t; start = s; bar_1_y = 10'(b1); bar_2_y = 10'(b2);
    @(posedge clk);
    model_step(t, s, b1, b2);
    #1;
    compare_all(ph);
  endtask

  // Reset asserted between edges must take effect before the next edge.
  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    check_value("arst.x", 32'(x), CENTER_X);
    check_value("arst.y", 32'(y), CENTER_Y);
    check_value("arst.state", 32'(state), 0);
    check_value("arst.score_1", 32'(score_1), 0);
    check_value("arst.score_2", 32'(score_2), 0);
    check_value("arst.point_1", 32'(point_1), 0);
    check_value("arst.point_2", 32'(point_2), 0);
    model_reset();
    tick = 1'b1;
    @(posedge clk);
    #1;
    compare_all("arst_hold");
    reset = 1'b1;
  endtask

  function automatic int clamp_bar(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  initial begin
    int off1, off2, b1, b2;
    bit seen, pend_rst;
    reset = 1'b0; tick = 1'b0; start = 1'b0; bar_1_y = '0; bar_2_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b1;

    // Serve: held at centre for SERVE_TICKS ticks, then moving right.
    for (int k = 0; k < SERVE_TICKS - 1; k++) drive_step("serve", 1'b1, 1'b0, 0, 0);
    check_value("serve_still_serving", 32'(state), 0);
    drive_step("serve", 1'b1, 1'b0, 0, 0);
    check_value("serve_to_play", 32'(state), 1);
    drive_step("first_move", 1'b1, 1'b0, 0, 0);
    check_value("first_move_x", 32'(x), CENTER_X + 1);

    // Paddle 2 far away: ball runs out on the right.
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      drive_step("miss2", 1'b1, 1'b0, 0, 0);
      seen = point_1;
    end
    check_value("point_1_seen", 32'(seen), 1);
    check_value("point_1_score", 32'(score_1), 1);
    check_value("point_1_recentre_x", 32'(x), CENTER_X);
    check_value("point_1_state", 32'(state), 0);
    drive_step("pulse", 1'b1, 1'b0, 0, CENTER_Y);
    check_value("point_1_one_clk", 32'(point_1), 0);

    // Paddle 2 returns every ball, paddle 1 misses: player 2 wins 7-1.
    seen = 1'b0;
    for (int k = 0; k < 12000 && !seen; k++) begin
      drive_step("p2_wins", 1'b1, 1'b0, 0, CENTER_Y);
      seen = game_over;
    end
    check_value("over_seen", 32'(seen), 1);
    check_value("over_score_2", 32'(score_2), WIN_SCORE);
    check_value("over_score_1", 32'(score_1), 1);
    check_value("over_state", 32'(state), 2);
    repeat (5) drive_step("over_hold", 1'b1, 1'b0, 0, CENTER_Y);
    drive_step("restart", 1'b0, 1'b1, 0, CENTER_Y);
    check_value("restart_state", 32'(state), 0);
    check_value("restart_score_2", 32'(score_2), 0);

    // Randomized play with tracking paddles, random start pulses and resets.
    off1 = 0; off2 = 0; pend_rst = 1'b0;
    for (int i = 0; i < 40000 && n_errors < 50; i++) begin
      if ($urandom_range(0, 299) == 0) off1 = int'($urandom_range(0, 100)) - 50;
      if ($urandom_range(0, 299) == 0) off2 = int'($urandom_range(0, 100)) - 50;
      b1 = clamp_bar(m_y + off1);
      b2 = clamp_bar(m_y + off2);
      if (pend_rst && m_state == 1 && $urandom_range(0, 49) == 0) begin
        async_reset();
        pend_rst = 1'b0;
      end else begin
        drive_step("rand", $urandom_range(0, 7) != 0,
                   (m_state == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0),
                   b1, b2);
      end
      if (i % 10000 == 9999) pend_rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
